// File: rtl/lsu_mem_master.sv
// Load/store initiator: RISC-V loads/stores onto a word-wide data memory port with RMW for sb/sh.
// Optional misalignment trapping is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_master #(
   parameter int MEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        areset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);
   localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d, err_q, err_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d, rdata_q, rdata_d;

   logic        bad_f3, oob, misalign, req_err;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_ext, merged;

   always_comb begin
      if (req_we) bad_f3 = req_funct3[2] | (req_funct3[1:0] == 2'b11);
      else        bad_f3 = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
      oob      = ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
      misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      case (req_funct3[1:0])
         2'b01:   misalign = req_addr[0];
         2'b10:   misalign = |req_addr[1:0];
         default: misalign = 1'b0;
      endcase
`endif
      req_err = bad_f3 | oob | misalign;
   end

   // Lane extraction for loads and lane replacement for sb/sh, both keyed off the latched address.
   always_comb begin
      lane_b = mem_rd[{addr_q[1:0], 3'b000} +: 8];
      lane_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{lane_b[7]}}, lane_b};
         3'b001:  ld_ext = {{16{lane_h[15]}}, lane_h};
         3'b100:  ld_ext = {24'h0, lane_b};
         3'b101:  ld_ext = {16'h0, lane_h};
         default: ld_ext = mem_rd;
      endcase
      merged = merge_q;
      if (f3_q[0]) merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      else         merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
   end

   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      f3_d      = f3_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      merge_d   = merge_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      mem_a     = 32'h0;
      mem_wd    = 32'h0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               rdata_d = 32'h0;
               err_d   = req_err;
               state_d = req_err ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            mem_a = {2'b00, addr_q[31:2]};
            if (!we_q) begin
               rdata_d = ld_ext;
               state_d = RESP;
            end else if (f3_q[1]) begin
               mem_we  = 1'b1;
               mem_wd  = wdata_q;
               state_d = RESP;
            end else begin
               merge_d = mem_rd;
               state_d = WRITE;
            end
         end
         WRITE: begin
            mem_a   = {2'b00, addr_q[31:2]};
            mem_we  = 1'b1;
            mem_wd  = merged;
            state_d = RESP;
         end
         default: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge areset) begin
      if (!areset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         merge_q <= 32'h0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         merge_q <= merge_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Table-driven bench for lsu_mem_master with a scoreboard of expected responses and a word memory model.
module tb_lsu_mem_master;
   logic        clk = 1'b0;
   logic        areset;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        mem_we;
   logic [31:0] mem_a, mem_wd, mem_rd;

   lsu_mem_master #(.MEM_WORDS(64)) dut (
      .clk(clk), .areset(areset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [64];
   logic        mem_init;
   assign mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : 32'h0;
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else if (mem_we && mem_a < 32'd64) begin
         mem[mem_a[5:0]] <= mem_wd;
      end
   end

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_wd;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   vec_t vt[$];
   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                               logic [31:0] rd, logic err, logic [31:0] mwd);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
      v.exp_rdata = rd; v.exp_err = err; v.exp_wd = mwd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one request, observe the memory port until the response, then accept it.
   task automatic run_req(input vec_t v, input string tag);
      exp_t        e;
      logic        got;
      int          lat, we_cnt;
      logic [31:0] wa, wd;
      logic        exp_we;
      exp_we  = v.we && !v.exp_err;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      e.lat   = v.exp_err ? 0 : ((v.we && v.f3 != 3'b010) ? 2 : 1);
      sbq.push_back(e);
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0; lat = -1; we_cnt = 0; wa = 32'h0; wd = 32'h0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (k == 0 && !v.exp_err) begin
            chk({tag, "_access_a"}, mem_a, v.addr >> 2);
            chk({tag, "_access_we"}, {31'h0, mem_we}, {31'h0, exp_we && v.f3 == 3'b010});
         end
         if (mem_we) begin we_cnt++; wa = mem_a; wd = mem_wd; end
         if (rsp_valid) begin got = 1'b1; lat = k; end
      end
      e = sbq.pop_front();
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_rsp required=rsp_valid", tag);
      end else begin
         chk({tag, "_rdata"}, rsp_rdata, e.rdata);
         chk({tag, "_err"}, {31'h0, rsp_err}, {31'h0, e.err});
         chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
      end
      chk({tag, "_we_cycles"}, 32'(we_cnt), exp_we ? 32'd1 : 32'd0);
      if (exp_we) begin
         chk({tag, "_wa"}, wa, v.addr >> 2);
         chk({tag, "_wd"}, wd, v.exp_wd);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t   v;
      exp_t   e;
      logic   got;
      areset = 1'b0; mem_init = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      rsp_ready = 1'b0;

      vt.push_back(mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0, 32'hDEADBEEF));
      vt.push_back(mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 0, 32'h0));
      vt.push_back(mk(0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 0, 32'h0));
      vt.push_back(mk(0, 3'b001, 32'h10,  32'h0,        32'hFFFFBEEF, 0, 32'h0));
      vt.push_back(mk(0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0, 32'h0));
      vt.push_back(mk(1, 3'b000, 32'h11,  32'hFFFFFF55, 32'h0,        0, 32'hDEAD55EF));
      vt.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD55EF, 0, 32'h0));
      vt.push_back(mk(0, 3'b010, 32'h100, 32'h0,        32'h0,        1, 32'h0));
      vt.push_back(mk(1, 3'b010, 32'h100, 32'h12345678, 32'h0,        1, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
      vt.push_back(mk(0, 3'b010, 32'h12,  32'h0,        32'h0,        1, 32'h0));
      vt.push_back(mk(0, 3'b001, 32'h11,  32'h0,        32'h0,        1, 32'h0));
`else
      vt.push_back(mk(0, 3'b010, 32'h12,  32'h0,        32'hDEAD55EF, 0, 32'h0));
      vt.push_back(mk(0, 3'b001, 32'h11,  32'h0,        32'h000055EF, 0, 32'h0));
`endif
      vt.push_back(mk(1, 3'b001, 32'h16,  32'h1234ABCD, 32'h0,        0, 32'hABCD0000));
      vt.push_back(mk(0, 3'b010, 32'h14,  32'h0,        32'hABCD0000, 0, 32'h0));
      vt.push_back(mk(0, 3'b011, 32'h10,  32'h0,        32'h0,        1, 32'h0));
      vt.push_back(mk(0, 3'b110, 32'h10,  32'h0,        32'h0,        1, 32'h0));
      vt.push_back(mk(1, 3'b100, 32'h10,  32'h000000AA, 32'h0,        1, 32'h0));
      vt.push_back(mk(1, 3'b010, 32'hFC,  32'h00000080, 32'h0,        0, 32'h00000080));
      vt.push_back(mk(0, 3'b000, 32'hFC,  32'h0,        32'hFFFFFF80, 0, 32'h0));
      vt.push_back(mk(0, 3'b000, 32'h1FC, 32'h0,        32'h0,        1, 32'h0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_a", mem_a, 32'h0);
      chk("rst_mem_wd", mem_wd, 32'h0);
      mem_init = 1'b0;
      areset = 1'b1;

      foreach (vt[i]) run_req(vt[i], $sformatf("vec%0d", i));

      // Backpressure: response held three cycles while a second request waits.
      e.rdata = 32'hDEAD55EF; e.err = 1'b0; e.lat = 1;
      sbq.push_back(e);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk);
      #1 req_addr = 32'h14;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid) got = 1'b1;
      end
      e = sbq.pop_front();
      if (!got) begin
         checks++; errors++;
         $display("FAIL bp_timeout actual=no_rsp required=rsp_valid");
      end
      for (int c = 0; c < 3; c++) begin
         if (c > 0) @(negedge clk);
         chk("bp_rsp_valid", {31'h0, rsp_valid}, 32'h1);
         chk("bp_rsp_rdata", rsp_rdata, e.rdata);
         chk("bp_rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
         chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
         chk("bp_mem_we", {31'h0, mem_we}, 32'h0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_idle_req_ready", {31'h0, req_ready}, 32'h1);
      chk("bp_idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      req_valid = 1'b0;

      // Reset landing on the WRITE cycle of an sb must drop the write.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h77;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rmw_access_we", {31'h0, mem_we}, 32'h0);
      chk("rmw_access_a", mem_a, 32'h8);
      @(negedge clk);
      chk("rmw_write_we", {31'h0, mem_we}, 32'h1);
      chk("rmw_write_wd", mem_wd, 32'h00000077);
      areset = 1'b0;
      #1;
      chk("rstw_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rstw_mem_a", mem_a, 32'h0);
      chk("rstw_req_ready", {31'h0, req_ready}, 32'h1);
      chk("rstw_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      @(negedge clk);
      areset = 1'b1;
      @(negedge clk);
      chk("rstw_word8", mem[8], 32'h0);
      chk("rstw_idle_ready", {31'h0, req_ready}, 32'h1);
      v = mk(0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 0, 32'h0);
      run_req(v, "post_rst_lw");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
